mem_burst_master: RTL and testbench

Burst initiator for the single-port-style `memory` RAM (one write port, one registered read port, shared `en`/`wr`). It accepts read or write burst commands on a valid/ready command channel and streams write data in from a valid/ready source. It drives the RAM strobes and addresses, and returns read data on a valid/ready stream with full backpressure. It sits between a DMA/CPU-side client and a `memory` instance with matching `ADDR_LINES`/`LOC_SIZE`.

---
 rtl/mem_burst_pkg.sv | 16 +
 rtl/mem_burst_master_if.sv | 45 ++++
 rtl/mem_rd_skid.sv | 57 +++++
 rtl/mem_burst_master.sv | 155 +++++++++++++++
 tb/tb_mem_burst_master.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_burst_pkg.sv
// Shared types and constants for the mem_burst_master slice.
package mem_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } mem_burst_state_t;

  // Read-return FIFO depth; two entries cover the RAM read latency at full rate.
  localparam int RD_FIFO_DEPTH = 2;
  localparam int RD_PTR_W      = $clog2(RD_FIFO_DEPTH);
  localparam int RD_OCC_W      = $clog2(RD_FIFO_DEPTH + 1);

endpackage

// File: rtl/mem_burst_master_if.sv
// Client command/data streams plus RAM port of the burst master.
// The master modport is the burst master's view; slave is the client/RAM side.
interface mem_burst_master_if #(
  parameter int ADDR_LINES = 10,
  parameter int LOC_SIZE   = 32,
  parameter int LEN_W      = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_wr;
  logic [ADDR_LINES-1:0] cmd_addr;
  logic [LEN_W-1:0]      cmd_len;

  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [LOC_SIZE-1:0]   wdata;

  logic                  rdata_valid;
  logic                  rdata_ready;
  logic [LOC_SIZE-1:0]   rdata;

  logic                  busy;
  logic                  done;

  logic                  mem_en;
  logic                  mem_wr;
  logic [ADDR_LINES-1:0] mem_rd_addr;
  logic [ADDR_LINES-1:0] mem_wr_addr;
  logic [LOC_SIZE-1:0]   mem_wr_data;
  logic [LOC_SIZE-1:0]   mem_rd_data;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len,
    input  wdata_valid, wdata, rdata_ready, mem_rd_data,
    output cmd_ready, wdata_ready, rdata_valid, rdata, busy, done,
    output mem_en, mem_wr, mem_rd_addr, mem_wr_addr, mem_wr_data
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len,
    output wdata_valid, wdata, rdata_ready, mem_rd_data,
    input  cmd_ready, wdata_ready, rdata_valid, rdata, busy, done,
    input  mem_en, mem_wr, mem_rd_addr, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/mem_rd_skid.sv
// Two-entry synchronous FIFO holding RAM read words until the client takes them.
// Head word is presented on dout and stays put until popped.
module mem_rd_skid
  import mem_burst_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                push,
  input  logic                pop,
  input  logic [W-1:0]        din,
  output logic [W-1:0]        dout,
  output logic [RD_OCC_W-1:0] occ,
  output logic                valid
);
  logic [W-1:0]        slot_r [RD_FIFO_DEPTH];
  logic [RD_PTR_W-1:0] wr_ptr_r;
  logic [RD_PTR_W-1:0] rd_ptr_r;
  logic [RD_OCC_W-1:0] occ_r;
  logic                push_ok_s;
  logic                pop_ok_s;

  // Qualify push/pop so the FIFO can never over- or under-run.
  always_comb begin
    push_ok_s = push && ((occ_r != RD_OCC_W'(RD_FIFO_DEPTH)) || pop);
    pop_ok_s  = pop && (occ_r != {RD_OCC_W{1'b0}});
  end

  // Storage, pointers and occupancy; clear empties and zeroes everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < RD_FIFO_DEPTH; i++) begin
        slot_r[i] <= {W{1'b0}};
      end
      wr_ptr_r <= {RD_PTR_W{1'b0}};
      rd_ptr_r <= {RD_PTR_W{1'b0}};
      occ_r    <= {RD_OCC_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        slot_r[wr_ptr_r] <= din;
        wr_ptr_r         <= wr_ptr_r + RD_PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + RD_PTR_W'(1);
      end
      occ_r <= occ_r + RD_OCC_W'(push_ok_s) - RD_OCC_W'(pop_ok_s);
    end
  end

  // Head word and status.
  always_comb begin
    dout  = slot_r[rd_ptr_r];
    occ   = occ_r;
    valid = (occ_r != {RD_OCC_W{1'b0}});
  end
endmodule

// File: rtl/mem_burst_master.sv
// Burst initiator for a one-write-port / registered-read-port RAM.
// Write bursts pass client words straight to the RAM; read bursts are issued
// against a credit so that at most two words are ever outstanding.
module mem_burst_master
  import mem_burst_pkg::*;
#(
  parameter int ADDR_LINES = 10,
  parameter int LOC_SIZE   = 32,
  parameter int LEN_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  mem_burst_master_if.master bus
);
  localparam int CREDIT_W = RD_OCC_W + 1;

  mem_burst_state_t      state_r;
  mem_burst_state_t      state_s;
  logic [ADDR_LINES-1:0] addr_r;
  logic [ADDR_LINES-1:0] addr_s;
  logic [LEN_W-1:0]      cnt_r;
  logic [LEN_W-1:0]      cnt_s;
  logic                  inflight_r;
  logic                  done_r;
  logic                  done_s;
  logic                  beat_s;
  logic                  issue_s;
  logic                  pop_s;
  logic [RD_OCC_W-1:0]   occ_s;
  logic [CREDIT_W-1:0]   credit_s;
  logic                  fifo_valid_s;
  logic [LOC_SIZE-1:0]   fifo_dout_s;

  // The RAM read word arrives the cycle after issue, which is when inflight_r is set.
  mem_rd_skid #(
    .W (LOC_SIZE)
  ) u_rd_skid (
    .clk   (clk),
    .clr   (rst),
    .push  (inflight_r),
    .pop   (pop_s),
    .din   (bus.mem_rd_data),
    .dout  (fifo_dout_s),
    .occ   (occ_s),
    .valid (fifo_valid_s)
  );

  // Words that will be held or arriving once this cycle's pop retires.
  always_comb begin
    pop_s    = fifo_valid_s && bus.rdata_ready && !rst;
    credit_s = CREDIT_W'(occ_s) + CREDIT_W'(inflight_r) - CREDIT_W'(pop_s);
  end

  // Next-state, address/count update and strobe decisions.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    cnt_s   = cnt_r;
    done_s  = 1'b0;
    beat_s  = 1'b0;
    issue_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          addr_s = bus.cmd_addr;
          cnt_s  = bus.cmd_len;
          if (bus.cmd_wr) begin
            state_s = ST_WRITE;
          end else begin
            state_s = ST_READ;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (bus.wdata_valid) begin
          beat_s = 1'b1;
          addr_s = addr_r + ADDR_LINES'(1);
          cnt_s  = cnt_r - LEN_W'(1);
          if (cnt_r == {LEN_W{1'b0}}) begin
            state_s = ST_IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = ST_WRITE;
          end
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_READ: begin
        if (credit_s < CREDIT_W'(RD_FIFO_DEPTH)) begin
          issue_s = 1'b1;
          addr_s  = addr_r + ADDR_LINES'(1);
          cnt_s   = cnt_r - LEN_W'(1);
          if (cnt_r == {LEN_W{1'b0}}) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_READ;
          end
        end else begin
          state_s = ST_READ;
        end
      end
      ST_DRAIN: begin
        // Leave as the last word is popped so done lands right after it.
        if (credit_s == {CREDIT_W{1'b0}}) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, address, count, inflight and done registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      addr_r     <= {ADDR_LINES{1'b0}};
      cnt_r      <= {LEN_W{1'b0}};
      inflight_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      addr_r     <= addr_s;
      cnt_r      <= cnt_s;
      inflight_r <= issue_s;
      done_r     <= done_s;
    end
  end

  // Drive the bus; everything is forced quiet while rst is high.
  always_comb begin
    bus.cmd_ready   = !rst && (state_r == ST_IDLE);
    bus.wdata_ready = !rst && (state_r == ST_WRITE);
    bus.rdata_valid = !rst && fifo_valid_s;
    bus.rdata       = fifo_dout_s;
    bus.busy        = (state_r != ST_IDLE);
    bus.done        = done_r;
    bus.mem_en      = !rst && (beat_s || issue_s);
    bus.mem_wr      = !rst && beat_s;
    bus.mem_rd_addr = addr_r;
    bus.mem_wr_addr = addr_r;
    if (!rst && beat_s) begin
      bus.mem_wr_data = bus.wdata;
    end else begin
      bus.mem_wr_data = {LOC_SIZE{1'b0}};
    end
  end
endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a behavioural registered-read RAM.
module tb_mem_burst_master;
  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_burst_master_if #(.ADDR_LINES(10), .LOC_SIZE(32), .LEN_W(8)) bus ();

  mem_burst_master #(.ADDR_LINES(10), .LOC_SIZE(32), .LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: write port plus registered read port, shared en/wr.
  logic [31:0] ram [1024];
  logic [31:0] rd_q;
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_wr) ram[bus.mem_wr_addr] <= bus.mem_wr_data;
    if (bus.mem_en && !bus.mem_wr) rd_q <= ram[bus.mem_rd_addr];
  end
  assign bus.mem_rd_data = rd_q;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Event logs filled by the monitor, read by the main flow after a posedge.
  int          cyc = 0;
  int          acc_cyc = 0;
  int          done_cyc = 0;
  int          en_n = 0;
  int          out_cnt = 0;
  logic [9:0]  wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          wr_cyc_q  [$];
  logic [31:0] pop_data_q [$];
  int          pop_cyc_q  [$];

  // Monitor at negedge: log handshakes, check pending limit, stall stability and strobe legality.
  initial begin
    logic        stall_prev;
    logic [31:0] hold_val;
    stall_prev = 1'b0;
    hold_val   = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        out_cnt    = 0;
        stall_prev = 1'b0;
        if (bus.mem_en) check_eq("en_in_rst", {31'b0, bus.mem_en}, 32'd0);
      end else begin
        if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;
        if (bus.mem_en) begin
          en_n++;
          check_eq("en_legal", {31'b0, bus.busy}, 32'd1);
        end
        if (bus.mem_en && bus.mem_wr) begin
          wr_addr_q.push_back(bus.mem_wr_addr);
          wr_data_q.push_back(bus.mem_wr_data);
          wr_cyc_q.push_back(cyc);
        end
        if (bus.rdata_valid && bus.rdata_ready) begin
          pop_data_q.push_back(bus.rdata);
          pop_cyc_q.push_back(cyc);
          out_cnt--;
        end
        if (bus.mem_en && !bus.mem_wr) begin
          out_cnt++;
          check_eq("rd_pending", {31'b0, out_cnt <= 2}, 32'd1);
        end
        if (stall_prev && bus.rdata_valid) check_eq("rd_stable", bus.rdata, hold_val);
        stall_prev = bus.rdata_valid && !bus.rdata_ready;
        hold_val   = bus.rdata;
        if (bus.done) done_cyc = cyc;
      end
    end
  end

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    pop_data_q.delete(); pop_cyc_q.delete();
    en_n = 0;
  endtask

  // Offer a command until accepted; returns at posedge+1 of the first burst cycle.
  task automatic send_cmd(input logic wr, input logic [9:0] a, input logic [7:0] l);
    int   b;
    logic ok;
    b = 0; ok = 1'b0;
    bus.cmd_wr = wr; bus.cmd_addr = a; bus.cmd_len = l; bus.cmd_valid = 1'b1;
    while (!ok && b < 20) begin
      @(negedge clk);
      if (bus.cmd_ready) ok = 1'b1;
      @(posedge clk); #1;
      b++;
    end
    bus.cmd_valid = 1'b0;
    check_eq("cmd_accept", {31'b0, ok}, 32'd1);
  endtask

  logic [31:0] wbuf [8];

  // Write burst from wbuf with a repeating wdata_valid pattern, then wait for done.
  task automatic write_burst(input logic [9:0] a, input logic [7:0] l,
                             input logic [15:0] pat, input int pat_n);
    int   idx, k;
    logic got;
    idx = 0; k = 0; got = 1'b0;
    clear_logs();
    send_cmd(1'b1, a, l);
    while (idx <= int'(l) && k < 100) begin
      bus.wdata_valid = pat[k % pat_n];
      bus.wdata       = wbuf[idx];
      @(negedge clk);
      if (bus.wdata_valid && bus.wdata_ready) idx++;
      @(posedge clk); #1;
      k++;
    end
    bus.wdata_valid = 1'b0;
    bus.wdata       = 32'h0;
    check_eq("wr_beats", idx, int'(l) + 1);
    k = 0;
    while (!got && k < 20) begin
      @(negedge clk);
      if (bus.done) got = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    check_eq("wr_done_seen", {31'b0, got}, 32'd1);
  endtask

  // Read burst with a repeating rdata_ready pattern, running until done.
  task automatic read_burst(input logic [9:0] a, input logic [7:0] l,
                            input logic [15:0] pat, input int pat_n);
    int   k;
    logic got;
    k = 0; got = 1'b0;
    clear_logs();
    send_cmd(1'b0, a, l);
    while (!got && k < 200) begin
      bus.rdata_ready = pat[k % pat_n];
      @(negedge clk);
      if (bus.done) got = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    bus.rdata_ready = 1'b0;
    check_eq("rd_done_seen", {31'b0, got}, 32'd1);
  endtask

  logic [31:0] dat_a [4] = '{32'hA000_00A0, 32'hA000_00A1, 32'hA000_00A2, 32'hA000_00A3};
  logic [31:0] dat_b [4] = '{32'hB000_00B0, 32'hB000_00B1, 32'hB000_00B2, 32'hB000_00B3};
  logic [31:0] dat_c [4] = '{32'hC000_00C0, 32'hC000_00C1, 32'hC000_00C2, 32'hC000_00C3};
  logic [31:0] dat_d [4] = '{32'hD000_00D0, 32'hD000_00D1, 32'hD000_00D2, 32'hD000_00D3};
  logic [9:0]  wrap_addr [4] = '{10'd1022, 10'd1023, 10'd0, 10'd1};
  int          gap_off [4] = '{1, 3, 4, 6};

  initial begin
    int b;
    bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_addr = 10'd0; bus.cmd_len = 8'd0;
    bus.wdata_valid = 1'b0; bus.wdata = 32'h0; bus.rdata_ready = 1'b0;

    // Reset state while rst is high.
    @(posedge clk); @(posedge clk); #1;
    check_eq("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
    check_eq("rst_wdata_ready", {31'b0, bus.wdata_ready}, 32'd0);
    check_eq("rst_rdata_valid", {31'b0, bus.rdata_valid}, 32'd0);
    check_eq("rst_rdata", bus.rdata, 32'h0);
    check_eq("rst_busy", {31'b0, bus.busy}, 32'd0);
    check_eq("rst_done", {31'b0, bus.done}, 32'd0);
    check_eq("rst_mem_en", {31'b0, bus.mem_en}, 32'd0);
    check_eq("rst_mem_wr", {31'b0, bus.mem_wr}, 32'd0);
    check_eq("rst_rd_addr", {22'b0, bus.mem_rd_addr}, 32'd0);
    check_eq("rst_wr_addr", {22'b0, bus.mem_wr_addr}, 32'd0);
    check_eq("rst_wr_data", bus.mem_wr_data, 32'h0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    @(posedge clk); #1;

    // Write addr 5 len 3, wdata_valid constant.
    for (int i = 0; i < 4; i++) wbuf[i] = dat_a[i];
    write_burst(10'd5, 8'd3, 16'h0001, 1);
    check_eq("w1_count", wr_addr_q.size(), 32'd4);
    check_eq("w1_en_count", en_n, 32'd4);
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      check_eq("w1_addr", {22'b0, wr_addr_q[i]}, 32'd5 + i);
      check_eq("w1_data", wr_data_q[i], dat_a[i]);
      check_eq("w1_cycle", wr_cyc_q[i], acc_cyc + 1 + i);
    end
    check_eq("w1_done_cycle", done_cyc, acc_cyc + 5);

    // Second write filling addr 9..12.
    for (int i = 0; i < 4; i++) wbuf[i] = dat_b[i];
    write_burst(10'd9, 8'd3, 16'h0001, 1);
    check_eq("w2_count", wr_addr_q.size(), 32'd4);

    // Read addr 5 len 3 at full rate.
    read_burst(10'd5, 8'd3, 16'h0001, 1);
    check_eq("r1_count", pop_data_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < pop_data_q.size(); i++) begin
      check_eq("r1_data", pop_data_q[i], dat_a[i]);
      check_eq("r1_cycle", pop_cyc_q[i], acc_cyc + 3 + i);
    end
    check_eq("r1_done_cycle", done_cyc, acc_cyc + 7);

    // Read len 7 with rdata_ready 1,0,0,1.
    read_burst(10'd5, 8'd7, 16'h0009, 4);
    check_eq("r2_count", pop_data_q.size(), 32'd8);
    for (int i = 0; i < 8 && i < pop_data_q.size(); i++) begin
      check_eq("r2_data", pop_data_q[i], (i < 4) ? dat_a[i] : dat_b[i-4]);
    end
    check_eq("r2_done_cycle", done_cyc, pop_cyc_q[pop_cyc_q.size()-1] + 1);

    // Address wrap write and read-back.
    for (int i = 0; i < 4; i++) wbuf[i] = dat_c[i];
    write_burst(10'd1022, 8'd3, 16'h0001, 1);
    check_eq("wrap_count", wr_addr_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      check_eq("wrap_addr", {22'b0, wr_addr_q[i]}, {22'b0, wrap_addr[i]});
    end
    read_burst(10'd1022, 8'd3, 16'h0001, 1);
    check_eq("wrap_rd_count", pop_data_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < pop_data_q.size(); i++) begin
      check_eq("wrap_rd_data", pop_data_q[i], dat_c[i]);
    end

    // Write with wdata_valid gaps 1,0,1,1,0,1.
    for (int i = 0; i < 4; i++) wbuf[i] = dat_d[i];
    write_burst(10'd20, 8'd3, 16'h002D, 6);
    check_eq("gap_count", wr_addr_q.size(), 32'd4);
    check_eq("gap_en_count", en_n, 32'd4);
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      check_eq("gap_cycle", wr_cyc_q[i], acc_cyc + gap_off[i]);
      check_eq("gap_addr", {22'b0, wr_addr_q[i]}, 32'd20 + i);
      check_eq("gap_data", wr_data_q[i], dat_d[i]);
    end

    // Reset mid-read after two beats.
    clear_logs();
    bus.rdata_ready = 1'b1;
    send_cmd(1'b0, 10'd5, 8'd7);
    b = 0;
    while (pop_data_q.size() < 2 && b < 50) begin
      @(posedge clk); #1;
      b++;
    end
    check_eq("mid_pops", pop_data_q.size(), 32'd2);
    rst = 1'b1;
    #1;
    check_eq("in_rst_mem_en", {31'b0, bus.mem_en}, 32'd0);
    check_eq("in_rst_rvalid", {31'b0, bus.rdata_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("after_rst_rvalid", {31'b0, bus.rdata_valid}, 32'd0);
    check_eq("after_rst_busy", {31'b0, bus.busy}, 32'd0);
    check_eq("after_rst_mem_en", {31'b0, bus.mem_en}, 32'd0);
    check_eq("after_rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    check_eq("rst_no_extra_pop", pop_data_q.size(), 32'd2);
    @(posedge clk); #1;

    // Single-word write after reset.
    wbuf[0] = 32'hE000_00E0;
    write_burst(10'd30, 8'd0, 16'h0001, 1);
    check_eq("len0_count", wr_addr_q.size(), 32'd1);
    if (wr_addr_q.size() > 0) begin
      check_eq("len0_addr", {22'b0, wr_addr_q[0]}, 32'd30);
      check_eq("len0_data", wr_data_q[0], 32'hE000_00E0);
    end
    check_eq("len0_done_cycle", done_cyc, acc_cyc + 2);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  // Hard stop if the flow ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
